// File: rtl/iir_out_decimator.sv
// Boxcar decimator for the IIR filter output: averages groups of 2**LOG2_DECIM
// samples, saturates to OUT_W bits and queues the results on a valid/ready stream.
module iir_out_decimator #(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 16,
    parameter int LOG2_DECIM = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic signed [IN_W-1:0]        in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_W-1:0]       out_data,
    output logic                          out_sat,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          ovf_sticky,
    output logic [15:0]                   ovf_cnt,
    input  logic                          ovf_clr
);

    localparam int ACC_W = IN_W + LOG2_DECIM;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = OUT_W + 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [LOG2_DECIM-1:0]    phase;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  in_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  avg;
    logic [OUT_W-1:0]         clamped;
    logic                     sat;

    logic [ENT_W-1:0]         mem [FIFO_DEPTH];
    logic [ENT_W-1:0]         head;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;

    logic group_done;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        in_ext  = {{LOG2_DECIM{in_data[IN_W-1]}}, in_data};
        sum     = acc + in_ext;
        avg     = sum >>> LOG2_DECIM;
        clamped = avg[OUT_W-1:0];
        sat     = 1'b0;
        if (avg > SAT_MAX) begin
            clamped = SAT_MAX[OUT_W-1:0];
            sat     = 1'b1;
        end else if (avg < SAT_MIN) begin
            clamped = SAT_MIN[OUT_W-1:0];
            sat     = 1'b1;
        end
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign group_done = in_valid && (phase == '1);
    assign full       = (fill_level == CNT_W'(FIFO_DEPTH));
    assign out_valid  = (fill_level != '0);
    assign pop        = out_valid && out_ready;
    assign push       = group_done && (!full || pop);
    assign drop       = group_done && full && !pop;

    assign head     = mem[rd_ptr];
    assign out_data = out_valid ? head[OUT_W-1:0] : '0;
    assign out_sat  = out_valid ? head[OUT_W] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase      <= '0;
            acc        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            ovf_sticky <= 1'b0;
            ovf_cnt    <= '0;
        end else begin
            if (in_valid) begin
                phase <= phase + 1'b1;
                acc   <= (phase == '0) ? in_ext : sum;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fill_level <= fill_level + 1'b1;
            else if (pop && !push) fill_level <= fill_level - 1'b1;

            if (ovf_clr) begin
                ovf_sticky <= 1'b0;
                ovf_cnt    <= '0;
            end else if (drop) begin
                ovf_sticky <= 1'b1;
                if (ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
            end
        end
    end

    // NOTE: the storage array has no reset; out_valid masks stale entries.
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= {sat, clamped};
    end

endmodule

// File: tb/tb_iir_out_decimator.sv
// Self-checking bench for iir_out_decimator: directed cases plus a randomized run
// compared every cycle against a queue-based behavioural model.
module tb_iir_out_decimator;

    localparam int IN_W  = 32;
    localparam int OUT_W = 16;
    localparam int L2D   = 2;
    localparam int DEPTH = 4;
    localparam int DECIM = 1 << L2D;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       in_valid;
    logic signed [IN_W-1:0]     in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [OUT_W-1:0]    out_data;
    logic                       out_sat;
    logic [$clog2(DEPTH):0]     fill_level;
    logic                       ovf_sticky;
    logic [15:0]                ovf_cnt;
    logic                       ovf_clr;

    iir_out_decimator #(
        .IN_W(IN_W), .OUT_W(OUT_W), .LOG2_DECIM(L2D), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .fill_level(fill_level), .ovf_sticky(ovf_sticky),
        .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pending group samples, FIFO contents and overflow counters.
    typedef struct { longint data; bit sat; } entry_t;
    longint  grp_q[$];
    entry_t  fifo_q[$];
    bit      m_sticky;
    longint  m_cnt;

    function automatic entry_t average(input longint s);
        entry_t e;
        longint q;
        q = s / DECIM;
        if (s < 0 && q * DECIM != s) q = q - 1;
        e.sat = 1'b0;
        e.data = q;
        if (q > 32767)       begin e.data = 32767;  e.sat = 1'b1; end
        else if (q < -32768) begin e.data = -32768; e.sat = 1'b1; end
        return e;
    endfunction

    always @(posedge clk) begin : model
        bit     do_pop, do_push, dropped;
        longint s;
        entry_t e;
        if (rst) begin
            grp_q.delete();
            fifo_q.delete();
            m_sticky = 1'b0;
            m_cnt    = 0;
        end else begin
            do_pop  = (fifo_q.size() > 0) && out_ready;
            do_push = 1'b0;
            dropped = 1'b0;
            if (in_valid) begin
                grp_q.push_back(longint'(in_data));
                if (grp_q.size() == DECIM) begin
                    s = 0;
                    foreach (grp_q[i]) s += grp_q[i];
                    e = average(s);
                    do_push = 1'b1;
                    grp_q.delete();
                end
            end
            if (do_pop) void'(fifo_q.pop_front());
            if (do_push) begin
                if (fifo_q.size() < DEPTH) fifo_q.push_back(e);
                else dropped = 1'b1;
            end
            if (ovf_clr) begin
                m_sticky = 1'b0;
                m_cnt    = 0;
            end else if (dropped) begin
                m_sticky = 1'b1;
                if (m_cnt != 65535) m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("cmp_out_valid", out_valid, fifo_q.size() > 0);
            check("cmp_out_data", out_data, fifo_q.size() > 0 ? fifo_q[0].data : 0);
            check("cmp_out_sat", out_sat, fifo_q.size() > 0 ? fifo_q[0].sat : 0);
            check("cmp_fill_level", fill_level, fifo_q.size());
            check("cmp_ovf_sticky", ovf_sticky, m_sticky);
            check("cmp_ovf_cnt", ovf_cnt, m_cnt);
        end
    end

    task automatic send(input longint v);
        in_valid = 1'b1;
        in_data  = v[IN_W-1:0];
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send4(input longint v);
        repeat (DECIM) send(v);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        @(negedge clk);
        check_en = 1'b1;
        @(negedge clk);
        check("reset_valid", out_valid, 0);
        check("reset_fill", fill_level, 0);
        check("reset_data", out_data, 0);
        check("reset_ovf_cnt", ovf_cnt, 0);
        rst = 1'b0;

        send(4); send(8); send(12);
        check("avg_not_yet", out_valid, 0);
        send(16);
        check("avg_valid", out_valid, 1);
        check("avg_data", out_data, 10);
        check("avg_sat", out_sat, 0);
        idle(1);
        check("avg_popped", out_valid, 0);

        send(-1); send(-1); send(-1); send(-2);
        check("floor_data", out_data, -2);
        check("floor_sat", out_sat, 0);
        idle(1);

        send4(100000);
        check("sat_pos_data", out_data, 32767);
        check("sat_pos_sat", out_sat, 1);
        idle(1);
        send4(-100000);
        check("sat_neg_data", out_data, -32768);
        check("sat_neg_sat", out_sat, 1);
        idle(1);

        out_ready = 1'b0;
        for (int g = 1; g <= 5; g++) send4(g * 100);
        check("ovf_fill", fill_level, 4);
        check("ovf_sticky", ovf_sticky, 1);
        check("ovf_cnt", ovf_cnt, 1);
        check("ovf_head", out_data, 100);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        check("clr_sticky", ovf_sticky, 0);
        check("clr_cnt", ovf_cnt, 0);

        send(600); send(600); send(600);
        out_ready = 1'b1;
        send(600);
        check("fullpp_fill", fill_level, 4);
        check("fullpp_cnt", ovf_cnt, 0);
        check("fullpp_head", out_data, 200);
        idle(3);
        check("fullpp_tail", out_data, 600);
        idle(1);

        send(50); send(50);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        send(1); idle(2); send(1); idle(1); send(1); idle(3); send(1);
        check("rst_gap_valid", out_valid, 1);
        check("rst_gap_data", out_data, 1);
        idle(1);
        send4(1);
        check("nogap_data", out_data, 1);
        idle(1);

        for (int c = 0; c < 3000; c++) begin
            int sel;
            sel = int'($urandom_range(0, 2));
            in_valid = ($urandom_range(0, 9) < 7);
            case (sel)
                0:       in_data = IN_W'($urandom_range(0, 80000)) - 40000;
                1:       in_data = IN_W'($urandom_range(0, 400)) - 200;
                default: in_data = $urandom;
            endcase
            if (c % 64 == 0) out_ready = ($urandom_range(0, 1) == 1);
            else if (out_ready == 1'b0 && $urandom_range(0, 15) == 0) out_ready = 1'b1;
            ovf_clr = ($urandom_range(0, 49) == 0);
            rst     = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        ovf_clr  = 1'b0;
        rst      = 1'b0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
